// File: rtl/uc_sequencer_if.sv
// Control bus between uc_sequencer (master) and the microc datapath (slave).
interface uc_sequencer_if;
  logic [5:0] Opcode;
  logic       z;
  logic       s_inc;
  logic       s_inm;
  logic       we3;
  logic       wez;
  logic [2:0] Op;
  logic       pc_en;

  modport master (
    input  Opcode, z,
    output s_inc, s_inm, we3, wez, Op, pc_en
  );

  modport slave (
    output Opcode, z,
    input  s_inc, s_inm, we3, wez, Op, pc_en
  );
endinterface

// File: rtl/uc_sequencer.sv
// microc control unit: instruction decoder wrapped in a run/pause/step/halt sequencer.
// Optional performance counters are built when PERF_CNT_EN is defined.
module uc_sequencer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  uc_sequencer_if.master dp,
  input  logic           start,
  input  logic           pause,
  input  logic           step,
  output logic           halted,
  output logic           error
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] cycle_cnt
`endif
);
  localparam int unsigned OP_W = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_PAUSE  = 3'd2,
    S_STEP   = 3'd3,
    S_HALTED = 3'd4,
    S_ERROR  = 3'd5
  } state_e;

  state_e state_q, state_d;
  logic   halted_q, halted_d;
  logic   error_q, error_d;
  logic   active, is_alu, is_li, is_jmp, is_halt, is_legal, retire;

  // Opcode classes; jumps and NOP share the 0001xx group.
  always_comb begin
    is_alu   = dp.Opcode[5];
    is_li    = (dp.Opcode[5:2] == 4'b0000);
    is_jmp   = (dp.Opcode[5:2] == 4'b0001);
    is_halt  = (dp.Opcode == 6'b001000);
    is_legal = is_alu | is_li | is_jmp | is_halt;
  end

  // Decode and next state; controls are live only in RUN and STEP.
  always_comb begin
    state_d  = state_q;
    dp.s_inc = 1'b1;
    dp.s_inm = 1'b0;
    dp.we3   = 1'b0;
    dp.wez   = 1'b0;
    dp.Op    = OP_W'(0);
    dp.pc_en = 1'b0;
    active   = (state_q == S_RUN) || (state_q == S_STEP);
    retire   = active & is_legal & ~is_halt;

    if (active) begin
      if (is_alu) begin
        dp.Op    = dp.Opcode[4:2];
        dp.we3   = 1'b1;
        dp.wez   = 1'b1;
        dp.pc_en = 1'b1;
      end else if (is_li) begin
        dp.s_inm = 1'b1;
        dp.we3   = 1'b1;
        dp.pc_en = 1'b1;
      end else if (is_jmp) begin
        dp.pc_en = 1'b1;
        case (dp.Opcode[1:0])
          2'b00:   dp.s_inc = 1'b0;
          2'b01:   dp.s_inc = ~dp.z;
          2'b10:   dp.s_inc = dp.z;
          default: dp.s_inc = 1'b1;
        endcase
      end
    end

    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN: begin
        if (is_halt)             state_d = S_HALTED;
        else if (!is_legal)      state_d = S_ERROR;
        else if (pause && !start) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (start)     state_d = S_RUN;
        else if (step) state_d = S_STEP;
      end
      S_STEP: begin
        if (is_halt)        state_d = S_HALTED;
        else if (!is_legal) state_d = S_ERROR;
        else                state_d = S_PAUSE;
      end
      S_HALTED, S_ERROR: state_d = state_q;
      default:           state_d = S_IDLE;
    endcase

    halted_d = (state_d == S_HALTED);
    error_d  = (state_d == S_ERROR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      halted_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      error_q  <= error_d;
    end
  end

  assign halted = halted_q;
  assign error  = error_q;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

  // Counters wrap naturally and freeze outside RUN/STEP.
  always_comb begin
    instr_cnt_d = instr_cnt_q + CNT_W'(retire);
    cycle_cnt_d = cycle_cnt_q + CNT_W'(active);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_cnt_q <= '0;
      cycle_cnt_q <= '0;
    end else begin
      instr_cnt_q <= instr_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign instr_cnt = instr_cnt_q;
  assign cycle_cnt = cycle_cnt_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{32'(CNT_W), retire};
`endif
endmodule

// File: tb/tb_uc_sequencer.sv
// Self-checking bench for uc_sequencer: decode table, hand sequences and a randomized run
// against a behavioural model of the sequencer rules.
module tb_uc_sequencer;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_STEP = 3, M_HALT = 4, M_ERR = 5;
  localparam int K_ALU = 0, K_LI = 1, K_J = 2, K_JZ = 3, K_JNZ = 4, K_NOP = 5, K_HALT = 6, K_ILL = 7;
  localparam logic [7:0] IDLE_V = 8'b1000_0000;

  logic clk, reset, start, pause, step;
  logic halted, error;
`ifdef PERF_CNT_EN
  logic [3:0] instr_cnt, cycle_cnt;
`endif

  uc_sequencer_if dp_if ();

  uc_sequencer #(.CNT_W(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .dp     (dp_if.master),
    .start  (start),
    .pause  (pause),
    .step   (step),
    .halted (halted),
    .error  (error)
`ifdef PERF_CNT_EN
    ,
    .instr_cnt (instr_cnt),
    .cycle_cnt (cycle_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int mode = M_IDLE;
  int ins_m = 0;
  int cyc_m = 0;

  typedef struct {
    logic [5:0] opc;
    logic       zz;
    logic [7:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ctrl_vec();
    return {dp_if.s_inc, dp_if.s_inm, dp_if.we3, dp_if.wez, dp_if.Op, dp_if.pc_en};
  endfunction

  function automatic int kind(input logic [5:0] opc);
    int o;
    o = int'(opc);
    if (o >= 32) return K_ALU;
    if (o < 4)   return K_LI;
    if (o == 4)  return K_J;
    if (o == 5)  return K_JZ;
    if (o == 6)  return K_JNZ;
    if (o == 7)  return K_NOP;
    if (o == 8)  return K_HALT;
    return K_ILL;
  endfunction

  function automatic logic [7:0] ref_ctrl(input int m, input logic [5:0] opc, input logic zz);
    if (m != M_RUN && m != M_STEP) return IDLE_V;
    case (kind(opc))
      K_ALU:   return {4'b1011, opc[4:2], 1'b1};
      K_LI:    return 8'b1110_0001;
      K_J:     return 8'b0000_0001;
      K_JZ:    return {~zz, 7'b000_0001};
      K_JNZ:   return {zz, 7'b000_0001};
      K_NOP:   return 8'b1000_0001;
      default: return IDLE_V;
    endcase
  endfunction

  function automatic int ref_next(input int m, input logic [5:0] opc, input logic st,
                                  input logic pa, input logic sp);
    int k;
    k = kind(opc);
    case (m)
      M_IDLE:  return st ? M_RUN : M_IDLE;
      M_RUN: begin
        if (k == K_HALT) return M_HALT;
        if (k == K_ILL)  return M_ERR;
        if (pa && !st)   return M_PAUSE;
        return M_RUN;
      end
      M_PAUSE: return st ? M_RUN : (sp ? M_STEP : M_PAUSE);
      M_STEP: begin
        if (k == K_HALT) return M_HALT;
        if (k == K_ILL)  return M_ERR;
        return M_PAUSE;
      end
      default: return m;
    endcase
  endfunction

  task automatic check_ctrl(input string name);
    chk(name, 32'(ctrl_vec()), 32'(ref_ctrl(mode, dp_if.Opcode, dp_if.z)));
  endtask

  // One rising edge: advance the model with the inputs present at the edge.
  task automatic cycle();
    int nxt, k;
    nxt = ref_next(mode, dp_if.Opcode, start, pause, step);
    k   = kind(dp_if.Opcode);
    @(posedge clk);
    if (mode == M_RUN || mode == M_STEP) begin
      cyc_m++;
      if (k != K_HALT && k != K_ILL) ins_m++;
    end
    mode = nxt;
    #1;
    chk("halted", 32'(halted), 32'(mode == M_HALT));
    chk("error", 32'(error), 32'(mode == M_ERR));
`ifdef PERF_CNT_EN
    chk("instr_cnt", 32'(instr_cnt), 32'(ins_m % 16));
    chk("cycle_cnt", 32'(cycle_cnt), 32'(cyc_m % 16));
`endif
  endtask

  // Reset asserted mid-cycle; controls must drop to idle at once.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mode  = M_IDLE;
    ins_m = 0;
    cyc_m = 0;
    #1;
    chk("reset_ctrl", 32'(ctrl_vec()), 32'(IDLE_V));
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_error", 32'(error), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  vec_t tbl[11];

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0; step = 1'b0;
    dp_if.Opcode = 6'd0; dp_if.z = 1'b0;

    tbl[0]  = '{6'b101000, 1'b0, 8'b1011_0101};
    tbl[1]  = '{6'b101100, 1'b0, 8'b1011_0111};
    tbl[2]  = '{6'b111111, 1'b1, 8'b1011_1111};
    tbl[3]  = '{6'b100000, 1'b0, 8'b1011_0001};
    tbl[4]  = '{6'b000011, 1'b0, 8'b1110_0001};
    tbl[5]  = '{6'b000100, 1'b1, 8'b0000_0001};
    tbl[6]  = '{6'b000101, 1'b1, 8'b0000_0001};
    tbl[7]  = '{6'b000101, 1'b0, 8'b1000_0001};
    tbl[8]  = '{6'b000110, 1'b1, 8'b1000_0001};
    tbl[9]  = '{6'b000110, 1'b0, 8'b0000_0001};
    tbl[10] = '{6'b000111, 1'b0, 8'b1000_0001};

    #1;
    chk("por_ctrl", 32'(ctrl_vec()), 32'(IDLE_V));
    chk("por_halted", 32'(halted), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Idle before start, then LI executes the cycle after start.
    #1;
    chk("idle_before_start", 32'(ctrl_vec()), 32'(IDLE_V));
    start = 1'b1;
    cycle();
    start = 1'b0;
    #1;
    chk("li_after_start", 32'(ctrl_vec()), 32'(8'b1110_0001));

    foreach (tbl[i]) begin
      dp_if.Opcode = tbl[i].opc;
      dp_if.z      = tbl[i].zz;
      #1;
      chk($sformatf("decode_%0d", i), 32'(ctrl_vec()), 32'(tbl[i].exp));
      cycle();
    end

    // Pause still executes the sampled instruction; step runs exactly one.
    dp_if.Opcode = 6'b000111;
    pause = 1'b1;
    #1;
    chk("pause_cycle_exec", 32'(dp_if.pc_en), 32'd1);
    cycle();
    pause = 1'b0;
    #1;
    chk("paused_pc_en", 32'(dp_if.pc_en), 32'd0);
    cycle();
    chk("paused_hold", 32'(dp_if.pc_en), 32'd0);
    step = 1'b1;
    cycle();
    step = 1'b0;
    #1;
    chk("step_pc_en", 32'(dp_if.pc_en), 32'd1);
    cycle();
    chk("after_step", 32'(dp_if.pc_en), 32'd0);
    step = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_ctrl("step_held");
      chk("step_held_pc_en", 32'(dp_if.pc_en), 32'(i % 2));
      cycle();
    end
    step = 1'b0;
    start = 1'b1;
    cycle();
    pause = 1'b1;
    cycle();
    #1;
    chk("pause_start_run", 32'(dp_if.pc_en), 32'd1);
    pause = 1'b0;
    start = 1'b0;

    // HALT is sticky until reset.
    dp_if.Opcode = 6'b001000;
    #1;
    chk("halt_ctrl", 32'(ctrl_vec()), 32'(IDLE_V));
    cycle();
    chk("halted_set", 32'(halted), 32'd1);
    start = 1'b1; step = 1'b1; dp_if.Opcode = 6'd0;
    #1;
    chk("halted_ctrl", 32'(ctrl_vec()), 32'(IDLE_V));
    cycle();
    chk("halted_sticky", 32'(halted), 32'd1);
    start = 1'b0; step = 1'b0;
    do_reset();
    chk("halt_cleared", 32'(halted), 32'd0);

    // Illegal opcode goes to ERROR with no writes.
    start = 1'b1;
    cycle();
    start = 1'b0;
    dp_if.Opcode = 6'b010000;
    #1;
    chk("illegal_ctrl", 32'(ctrl_vec()), 32'(IDLE_V));
    cycle();
    chk("error_set", 32'(error), 32'd1);

    // Reset mid-instruction kills the write immediately.
    do_reset();
    dp_if.Opcode = 6'd0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    dp_if.Opcode = 6'b100100;
    #1;
    chk("alu_we3", 32'(dp_if.we3), 32'd1);
    do_reset();
    chk("midreset_we3", 32'(dp_if.we3), 32'd0);

`ifdef PERF_CNT_EN
    dp_if.Opcode = 6'd0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (17) cycle();
    chk("instr_wrap", 32'(instr_cnt), 32'd1);
    chk("cycle_wrap", 32'(cycle_cnt), 32'd1);
    do_reset();
`endif

    // Randomized run against the model.
    for (int n = 0; n < 600; n++) begin
      int r;
      if ((mode == M_HALT || mode == M_ERR) && ($urandom_range(0, 1) == 0)) do_reset();
      r = int'($urandom_range(0, 9));
      if (r <= 5)      dp_if.Opcode = 6'($urandom_range(32, 63));
      else if (r <= 7) dp_if.Opcode = 6'($urandom_range(0, 7));
      else if (r == 8) dp_if.Opcode = 6'd8;
      else             dp_if.Opcode = 6'($urandom_range(9, 31));
      dp_if.z = 1'($urandom_range(0, 1));
      start   = ($urandom_range(0, 7) == 0);
      pause   = ($urandom_range(0, 3) == 0);
      step    = ($urandom_range(0, 2) == 0);
      #1;
      check_ctrl("rand_ctrl");
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
